bcd_countdown: RTL and testbench
================================

Name: bcd_countdown

Overview:
Six-digit BCD countdown timer, the down-counting counterpart of the stopwatch up-counter chain, using the same digit layout and the same 24-bit data format. It accepts a preset, then decrements once per internal timebase tick with borrow propagation. It stops at zero and flags expiry. Output `data` connects directly to the existing 7-segment display path.

Parameters:
TICK_DIV, 500000, clk cycles per decrement (integer >= 2; 500000 gives 100 Hz at 50 MHz)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  one-cycle pulse; capture preset
preset  input  24  BCD preset; same digit layout as data
start  input  1  one-cycle pulse; begin or resume counting
stop  input  1  one-cycle pulse; pause counting
data  output  24  current BCD value; d0=[3:0] .. d5=[23:20]
running  output  1  high while in RUN
done  output  1  sticky; high from reaching zero until next load or reset
expired  output  1  one-cycle pulse on the cycle data becomes zero

Behaviour:
- Digit ranges: d0, d1, d2, d4 are 0..9; d3 and d5 are 0..5.
- Reset (async, any time, including mid-count):
  - data=0, state IDLE.
  - running=0, done=0, expired=0.
  - Prescaler cleared.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority in a single cycle: load > stop > start.
- load (any state):
  - Next cycle: data = sanitized preset, state IDLE, prescaler cleared, done=0.
  - Sanitize rule: any digit above its maximum is clamped to that maximum (per digit, independently).
- start:
  - From IDLE with data != 0: go to RUN and clear the prescaler.
  - From PAUSE with data != 0: go to RUN and keep the prescaler phase.
  - Ignored when data == 0, in RUN, and in DONE.
- stop:
  - RUN -> PAUSE. The prescaler holds, and no decrement occurs that cycle even if a tick was due.
  - Ignored in all other states.
- Counting in RUN:
  - The prescaler counts 0..TICK_DIV-1 and then wraps to 0.
  - The wrap cycle is the tick. On each tick data decrements by exactly 1 in BCD.
  - Borrow rule: digit k decrements only when all lower digits are 0. A digit at 0 that borrows wraps to its own maximum (9 or 5).
  - Update is fully synchronous in one clock. No ripple or derived clocks.
- Terminal:
  - A tick with data == 0x000001 sets data=0 and moves to DONE.
  - done goes high and expired pulses for exactly 1 cycle, both registered and aligned with the data change.
  - DONE holds data=0 until load or reset. There is no wrap below zero.
- Outputs:
  - running = (state == RUN).
  - data changes only on load, on a tick, or on reset.
- Latency: command pulse at edge N takes effect at edge N+1.

Test Plan:
(TICK_DIV=4 for all scenarios)
1. Basic countdown: load preset=0x000012, then start -> data steps 0x12, 0x11, 0x10, 0x09 ... at one tick every 4 cycles. After 12 ticks: data=0x000000, done=1, expired high for exactly 1 cycle, running=0.
2. Borrow across mod-6 digits:
   - preset 0x010000, start -> after the first tick data=0x005999.
   - preset 0x100000 -> after the first tick data=0x095999.
3. Sanitize: preset 0xFFFFFF -> data=0x595999. Preset 0x6A0000 -> data=0x590000.
4. Pause/resume: stop 2 cycles after a tick -> data and prescaler frozen for 20 cycles, running=0. Then start -> the next decrement occurs exactly 2 cycles later (phase retained).
5. Zero and priority:
   - start with data=0 -> remains IDLE, running=0.
   - load together with start in RUN -> IDLE with the new value.
   - stop together with start in RUN -> PAUSE.
6. Reset mid-run: assert reset asynchronously between edges -> data=0, running=0, done=0 immediately. After release, start is ignored until a nonzero load.

Source files
------------

// File: rtl/bcd_countdown.sv
// Six-digit BCD countdown timer with preset load, start/stop control and expiry flags.
// Digit layout matches the stopwatch chain: d0=[3:0] .. d5=[23:20]; d3 and d5 are mod-6.
module bcd_countdown #(
    parameter int TICK_DIV = 500000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [23:0] i_preset,
    input  logic        i_start,
    input  logic        i_stop,
    output logic [23:0] o_data,
    output logic        o_running,
    output logic        o_done,
    output logic        o_expired
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [23:0]   r_data;
    logic [PW-1:0] r_presc;
    logic          r_done;
    logic          r_expired;

    logic          w_tick;
    logic          w_nonzero;
    logic [23:0]   w_dec;
    logic [23:0]   w_san;

    function automatic logic [3:0] digit_max(input int k);
        return (k == 3 || k == 5) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [23:0] sanitize(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        for (int k = 0; k < 6; k++) begin
            if (v[4*k +: 4] > digit_max(k))
                r[4*k +: 4] = digit_max(k);
        end
        return r;
    endfunction

    // A zero digit that still owes a borrow wraps to its own maximum.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = digit_max(k);
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Prescaler is a down-counter: TICK_DIV-1 is the cleared phase, zero is the tick.
    always_comb begin
        w_tick    = (r_state == S_RUN) && (r_presc == '0);
        w_nonzero = (r_data != '0);
        w_dec     = bcd_dec(r_data);
        w_san     = sanitize(i_preset);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_presc   <= PRESC_TOP;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (i_load) begin
                r_state <= S_IDLE;
                r_data  <= w_san;
                r_presc <= PRESC_TOP;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!i_stop && i_start && w_nonzero) begin
                            r_state <= S_RUN;
                            r_presc <= PRESC_TOP;
                        end
                    end
                    S_RUN: begin
                        if (i_stop) begin
                            r_state <= S_PAUSE;
                        end else if (w_tick) begin
                            r_presc <= PRESC_TOP;
                            r_data  <= w_dec;
                            if (r_data == 24'h000001) begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_expired <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc - PW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (!i_stop && i_start && w_nonzero)
                            r_state <= S_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_data    = r_data;
    assign o_running = (r_state == S_RUN);
    assign o_done    = r_done;
    assign o_expired = r_expired;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown at TICK_DIV=4: countdown, borrows, sanitize,
// pause/resume phase, command priority and asynchronous reset.
module tb_bcd_countdown;

    logic        clk;
    logic        reset;
    logic        load;
    logic [23:0] preset;
    logic        start;
    logic        stop;
    logic [23:0] data;
    logic        running;
    logic        done;
    logic        expired;

    int n_checks = 0;
    int n_errors = 0;

    bcd_countdown #(.TICK_DIV(4)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_load    (load),
        .i_preset  (preset),
        .i_start   (start),
        .i_stop    (stop),
        .o_data    (data),
        .o_running (running),
        .o_done    (done),
        .o_expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [23:0] v);
        load   = 1'b1;
        preset = v;
        step();
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [23:0] seq1 [12] = '{24'h11, 24'h10, 24'h09, 24'h08, 24'h07, 24'h06,
                               24'h05, 24'h04, 24'h03, 24'h02, 24'h01, 24'h00};

    initial begin
        reset = 1'b1; load = 1'b0; preset = '0; start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data, 24'h0);
        chk("rst_running", {23'h0, running}, 24'h0);
        chk("rst_done", {23'h0, done}, 24'h0);
        chk("rst_expired", {23'h0, expired}, 24'h0);
        @(negedge clk) reset = 1'b0;
        step();

        // basic countdown from 12
        do_load(24'h000012);
        chk("t1_load", data, 24'h000012);
        do_start();
        chk("t1_running", {23'h0, running}, 24'h1);
        for (int i = 0; i < 12; i++) begin
            repeat (3) step();
            chk("t1_hold", data, (i == 0) ? 24'h12 : seq1[i-1]);
            step();
            chk("t1_tick", data, seq1[i]);
            chk("t1_expired", {23'h0, expired}, (i == 11) ? 24'h1 : 24'h0);
        end
        chk("t1_done", {23'h0, done}, 24'h1);
        chk("t1_run_end", {23'h0, running}, 24'h0);
        step();
        chk("t1_exp_once", {23'h0, expired}, 24'h0);
        chk("t1_done_sticky", {23'h0, done}, 24'h1);
        do_start();
        chk("t1_start_in_done", {23'h0, running}, 24'h0);
        chk("t1_data_done", data, 24'h0);

        // borrow across mod-6 digits
        do_load(24'h010000);
        chk("t2_done_clr", {23'h0, done}, 24'h0);
        do_start();
        repeat (4) step();
        chk("t2_borrow_a", data, 24'h005999);
        do_load(24'h100000);
        chk("t2_load_idle", {23'h0, running}, 24'h0);
        do_start();
        repeat (4) step();
        chk("t2_borrow_b", data, 24'h095999);

        // sanitize
        do_load(24'hFFFFFF);
        chk("t3_san_ff", data, 24'h595999);
        do_load(24'h6A0000);
        chk("t3_san_6a", data, 24'h590000);

        // pause/resume retains prescaler phase
        do_load(24'h000050);
        do_start();
        repeat (4) step();
        chk("t4_first_tick", data, 24'h000049);
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_paused", {23'h0, running}, 24'h0);
        repeat (20) step();
        chk("t4_frozen", data, 24'h000049);
        chk("t4_frozen_run", {23'h0, running}, 24'h0);
        do_start();
        chk("t4_resumed", {23'h0, running}, 24'h1);
        step();
        chk("t4_resume_hold", data, 24'h000049);
        step();
        chk("t4_resume_tick", data, 24'h000048);
        repeat (3) step();
        chk("t4_next_hold", data, 24'h000048);
        step();
        chk("t4_next_tick", data, 24'h000047);

        // zero start and command priority
        do_load(24'h000000);
        do_start();
        chk("t5_zero_start", {23'h0, running}, 24'h0);
        chk("t5_zero_data", data, 24'h0);
        do_load(24'h000030);
        do_start();
        step();
        load = 1'b1; start = 1'b1; preset = 24'h000021;
        step();
        load = 1'b0; start = 1'b0;
        chk("t5_load_wins", {23'h0, running}, 24'h0);
        chk("t5_load_data", data, 24'h000021);
        do_start();
        step();
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("t5_stop_wins", {23'h0, running}, 24'h0);
        repeat (10) step();
        chk("t5_pause_hold", data, 24'h000021);
        do_start();
        chk("t5_resume", {23'h0, running}, 24'h1);

        // asynchronous reset mid-run
        do_load(24'h000030);
        do_start();
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_data", data, 24'h0);
        chk("t6_rst_running", {23'h0, running}, 24'h0);
        @(negedge clk) reset = 1'b0;
        step();
        do_start();
        chk("t6_start_ignored", {23'h0, running}, 24'h0);
        do_load(24'h000002);
        do_start();
        repeat (8) step();
        chk("t6_done_set", {23'h0, done}, 24'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_done", {23'h0, done}, 24'h0);
        @(negedge clk) reset = 1'b0;
        step();
        do_load(24'h000005);
        do_start();
        chk("t6_start_after_load", {23'h0, running}, 24'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
